// File: rtl/simple_connect_rr_arb_if.sv
// Handshake bundle between N_REQ requesters, the round-robin arbiter and the
// downstream sink. The arbiter uses the slave modport; the requester/sink side uses master.
interface simple_connect_rr_arb_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_rdy;
    logic [DW-1:0]       d_out;
    logic                d_out_vld;
    logic                d_out_rdy;
    logic [IW-1:0]       grant_id;

    modport master (
        output req_vld, req_data, req_last, d_out_rdy,
        input  req_rdy, d_out, d_out_vld, grant_id
    );

    modport slave (
        input  req_vld, req_data, req_last, d_out_rdy,
        output req_rdy, d_out, d_out_vld, grant_id
    );
endinterface

// File: rtl/simple_connect_rr_arb.sv
// Round-robin arbiter feeding a one-deep registered output stage.
// Define SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN to keep a grant locked until req_last.
module simple_connect_rr_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input logic                  clk,
    input logic                  resetn,
    simple_connect_rr_arb_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    rr_win;
    logic             rr_found;
    logic [IW-1:0]    sel;
    logic             eligible;
    logic             can_load;
    logic             grant_en;
    logic [N_REQ-1:0] rdy;
    logic [DW-1:0]    d_out_q;
    logic             d_out_vld_q;
    logic [IW-1:0]    grant_id_q;

`ifdef SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN
    typedef enum logic {ARB, LOCK} state_t;
    state_t        state;
    logic [IW-1:0] lk;
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
`endif

    assign can_load = !d_out_vld_q || bus.d_out_rdy;

    // Search starts just after the last winner so the previous winner has lowest priority.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!rr_found && bus.req_vld[(int'(ptr) + k) % N_REQ]) begin
                rr_found = 1'b1;
                rr_win   = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

`ifdef SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN
    assign sel      = (state == LOCK) ? lk : rr_win;
    assign eligible = (state == LOCK) ? bus.req_vld[lk] : rr_found;
`else
    assign sel      = rr_win;
    assign eligible = rr_found;
`endif

    // Nothing is accepted while reset is held, so no requester mistakes it for a transfer.
    assign grant_en = resetn && can_load && eligible;

    always_comb begin
        rdy = '0;
        if (grant_en) begin
            rdy[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_out_q     <= '0;
            d_out_vld_q <= 1'b0;
            grant_id_q  <= '0;
            ptr         <= IW'(N_REQ - 1);
`ifdef SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN
            state       <= ARB;
            lk          <= '0;
`endif
        end else begin
            if (grant_en) begin
                d_out_q     <= bus.req_data[sel*DW +: DW];
                grant_id_q  <= sel;
                d_out_vld_q <= 1'b1;
                ptr         <= sel;
`ifdef SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN
                if (state == ARB) begin
                    if (!bus.req_last[sel]) begin
                        state <= LOCK;
                        lk    <= sel;
                    end
                end else if (bus.req_last[lk]) begin
                    state <= ARB;
                end
`endif
            end else if (bus.d_out_rdy) begin
                d_out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.req_rdy   = rdy;
    assign bus.d_out     = d_out_q;
    assign bus.d_out_vld = d_out_vld_q;
    assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_simple_connect_rr_arb.sv
// Directed bench for simple_connect_rr_arb (N_REQ=4, DW=8); burst expectations
// follow SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN.
module tb_simple_connect_rr_arb;
    localparam int N_REQ = 4;
    localparam int DW    = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    simple_connect_rr_arb_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    simple_connect_rr_arb #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*DW +: DW] = v;
    endtask

    task automatic test_reset;
        bus.req_vld   = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.d_out_rdy = 1'b0;
        resetn        = 1'b0;
        tick();
        tick();
        vectors++; if (bus.d_out_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_vld got %b exp 0", bus.d_out_vld); end
        vectors++; if (bus.d_out !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data got %h exp 00", bus.d_out); end
        vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_gid got %0d exp 0", bus.grant_id); end
        #2 resetn = 1'b1;
        tick();
        // load a beat, then reset asynchronously mid-cycle
        bus.req_vld = 4'b0100;
        set_data(2, 8'h77);
        tick();
        vectors++; if (bus.d_out !== 8'h77) begin miscompares++; $display("[TB] FAIL pre_rst_data got %h exp 77", bus.d_out); end
        vectors++; if (bus.grant_id !== 2'd2) begin miscompares++; $display("[TB] FAIL pre_rst_gid got %0d exp 2", bus.grant_id); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (bus.d_out_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rst_vld got %b exp 0", bus.d_out_vld); end
        vectors++; if (bus.d_out !== 8'h00) begin miscompares++; $display("[TB] FAIL async_rst_data got %h exp 00", bus.d_out); end
        vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("[TB] FAIL async_rst_gid got %0d exp 0", bus.grant_id); end
        vectors++; if (bus.req_rdy !== 4'b0000) begin miscompares++; $display("[TB] FAIL async_rst_rdy got %b exp 0000", bus.req_rdy); end
        bus.req_vld = '0;
        #1 resetn = 1'b1;
    endtask

    task automatic test_rotation;
        logic [3:0] exp_rdy;
        bus.req_vld   = 4'b1111;
        bus.d_out_rdy = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        for (int c = 0; c < 8; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            vectors++; if (bus.req_rdy !== exp_rdy) begin miscompares++; $display("[TB] FAIL rot_rdy[%0d] got %b exp %b", c, bus.req_rdy, exp_rdy); end
            tick();
            vectors++; if (bus.d_out !== 8'hA0 + 8'(c % 4)) begin miscompares++; $display("[TB] FAIL rot_data[%0d] got %h exp %h", c, bus.d_out, 8'hA0 + 8'(c % 4)); end
            vectors++; if (bus.grant_id !== 2'(c % 4)) begin miscompares++; $display("[TB] FAIL rot_gid[%0d] got %0d exp %0d", c, bus.grant_id, c % 4); end
            vectors++; if (bus.d_out_vld !== 1'b1) begin miscompares++; $display("[TB] FAIL rot_vld[%0d] got %b exp 1", c, bus.d_out_vld); end
        end
        bus.req_vld = '0;
        tick();
        vectors++; if (bus.d_out_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL rot_drain_vld got %b exp 0", bus.d_out_vld); end
        vectors++; if (bus.d_out !== 8'hA3) begin miscompares++; $display("[TB] FAIL rot_hold_data got %h exp a3", bus.d_out); end
        vectors++; if (bus.grant_id !== 2'd3) begin miscompares++; $display("[TB] FAIL rot_hold_gid got %0d exp 3", bus.grant_id); end
    endtask

    task automatic test_backpressure;
        bus.d_out_rdy = 1'b0;
        bus.req_vld   = 4'b0100;
        set_data(2, 8'h5C);
        #1;
        vectors++; if (bus.req_rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL bp_first_rdy got %b exp 0100", bus.req_rdy); end
        tick();
        bus.req_vld = 4'b1000;
        set_data(3, 8'hD3);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (bus.req_rdy !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_rdy[%0d] got %b exp 0000", c, bus.req_rdy); end
            vectors++; if (bus.d_out !== 8'h5C) begin miscompares++; $display("[TB] FAIL bp_data[%0d] got %h exp 5c", c, bus.d_out); end
            vectors++; if (bus.d_out_vld !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_vld[%0d] got %b exp 1", c, bus.d_out_vld); end
            vectors++; if (bus.grant_id !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_gid[%0d] got %0d exp 2", c, bus.grant_id); end
            tick();
        end
        bus.d_out_rdy = 1'b1;
        #1;
        vectors++; if (bus.req_rdy !== 4'b1000) begin miscompares++; $display("[TB] FAIL bp_release_rdy got %b exp 1000", bus.req_rdy); end
        tick();
        vectors++; if (bus.d_out !== 8'hD3) begin miscompares++; $display("[TB] FAIL bp_next_data got %h exp d3", bus.d_out); end
        vectors++; if (bus.grant_id !== 2'd3) begin miscompares++; $display("[TB] FAIL bp_next_gid got %0d exp 3", bus.grant_id); end
        bus.req_vld = '0;
        tick();
        vectors++; if (bus.d_out_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain_vld got %b exp 0", bus.d_out_vld); end
    endtask

    task automatic test_wrap_skip;
        logic [3:0] exp_rdy [3];
        logic [7:0] exp_data [3];
        logic [1:0] exp_gid [3];
        exp_rdy  = '{4'b0001, 4'b0010, 4'b0001};
        exp_data = '{8'h01, 8'h11, 8'h01};
        exp_gid  = '{2'd0, 2'd1, 2'd0};
        // a lone grant to req 2 leaves the pointer at 2
        bus.req_vld = 4'b0100;
        set_data(2, 8'h22);
        tick();
        vectors++; if (bus.d_out !== 8'h22) begin miscompares++; $display("[TB] FAIL wrap_setup_data got %h exp 22", bus.d_out); end
        bus.req_vld = 4'b0011;
        set_data(0, 8'h01);
        set_data(1, 8'h11);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (bus.req_rdy !== exp_rdy[c]) begin miscompares++; $display("[TB] FAIL wrap_rdy[%0d] got %b exp %b", c, bus.req_rdy, exp_rdy[c]); end
            tick();
            vectors++; if (bus.d_out !== exp_data[c]) begin miscompares++; $display("[TB] FAIL wrap_data[%0d] got %h exp %h", c, bus.d_out, exp_data[c]); end
            vectors++; if (bus.grant_id !== exp_gid[c]) begin miscompares++; $display("[TB] FAIL wrap_gid[%0d] got %0d exp %0d", c, bus.grant_id, exp_gid[c]); end
        end
        bus.req_vld = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        bus.d_out_rdy = 1'b1;
        bus.req_vld   = 4'b0001;
        set_data(0, 8'h44);
        tick();
        vectors++; if (bus.d_out !== 8'h44) begin miscompares++; $display("[TB] FAIL b2b_first_data got %h exp 44", bus.d_out); end
        bus.req_vld = 4'b0010;
        set_data(1, 8'h33);
        #1;
        vectors++; if (bus.req_rdy !== 4'b0010) begin miscompares++; $display("[TB] FAIL b2b_rdy got %b exp 0010", bus.req_rdy); end
        tick();
        vectors++; if (bus.d_out !== 8'h33) begin miscompares++; $display("[TB] FAIL b2b_data got %h exp 33", bus.d_out); end
        vectors++; if (bus.d_out_vld !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_vld got %b exp 1", bus.d_out_vld); end
        vectors++; if (bus.grant_id !== 2'd1) begin miscompares++; $display("[TB] FAIL b2b_gid got %0d exp 1", bus.grant_id); end
        bus.req_vld = '0;
        tick();
    endtask

    task automatic test_no_request;
        bus.req_vld = '0;
        #1;
        vectors++; if (bus.req_rdy !== 4'b0000) begin miscompares++; $display("[TB] FAIL idle_rdy got %b exp 0000", bus.req_rdy); end
        tick();
        tick();
        vectors++; if (bus.d_out_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_vld got %b exp 0", bus.d_out_vld); end
        // pointer must still sit at 1 after idle cycles
        bus.req_vld = 4'b1111;
        #1;
        vectors++; if (bus.req_rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL idle_ptr_rdy got %b exp 0100", bus.req_rdy); end
        bus.req_vld = '0;
        #1;
    endtask

    task automatic test_burst;
        logic [3:0] exp_rdy [4];
        logic [7:0] exp_data [4];
        logic [1:0] exp_gid [4];
        int b1;
`ifdef SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN
        exp_rdy  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        exp_data = '{8'h10, 8'h11, 8'h12, 8'h2A};
        exp_gid  = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
        exp_rdy  = '{4'b0010, 4'b0100, 4'b0001, 4'b0010};
        exp_data = '{8'h10, 8'h2A, 8'h0A, 8'h11};
        exp_gid  = '{2'd1, 2'd2, 2'd0, 2'd1};
`endif
        bus.d_out_rdy = 1'b1;
        bus.req_vld   = 4'b0001;
        bus.req_last  = 4'b1111;
        set_data(0, 8'h0F);
        tick();
        vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("[TB] FAIL burst_setup_gid got %0d exp 0", bus.grant_id); end
        set_data(0, 8'h0A);
        set_data(2, 8'h2A);
        b1 = 0;
        for (int c = 0; c < 4; c++) begin
            bus.req_vld = {1'b0, 1'b1, (b1 < 3), 1'b1};
            bus.req_last = {1'b0, 1'b1, (b1 == 2), 1'b1};
            set_data(1, 8'h10 + 8'(b1));
            #1;
            vectors++; if (bus.req_rdy !== exp_rdy[c]) begin miscompares++; $display("[TB] FAIL burst_rdy[%0d] got %b exp %b", c, bus.req_rdy, exp_rdy[c]); end
            tick();
            vectors++; if (bus.d_out !== exp_data[c]) begin miscompares++; $display("[TB] FAIL burst_data[%0d] got %h exp %h", c, bus.d_out, exp_data[c]); end
            vectors++; if (bus.grant_id !== exp_gid[c]) begin miscompares++; $display("[TB] FAIL burst_gid[%0d] got %0d exp %0d", c, bus.grant_id, exp_gid[c]); end
            if (exp_rdy[c][1]) b1++;
        end
        bus.req_vld = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_back_to_back();
        test_no_request();
        test_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/simple_connect_rr_arb.md
Name: simple_connect_rr_arb

Overview:
- Round-robin arbiter that shares one DW-bit simple-connect data path between N_REQ requesters.
- Each requester uses a valid/ready handshake. The winning beat is registered into a one-deep output stage that drives d_out toward the downstream consumer.
- Sits in front of a simple-connect datapath when several sources must feed one sink.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 8, data width per requester and of d_out
- IW, $clog2(N_REQ), width of grant_id (local, derived)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous reset, active low
- req_vld  input  N_REQ  requester i has a beat pending
- req_data  input  N_REQ*DW  requester i data in bits [i*DW +: DW]
- req_last  input  N_REQ  beat is last of burst (used only with BURST_HOLD_EN)
- req_rdy  output  N_REQ  one-hot acceptance; beat i transfers when req_vld[i] & req_rdy[i]
- d_out  output  DW  registered data output
- d_out_vld  output  1  d_out holds a valid beat
- d_out_rdy  input  1  downstream accepts d_out this cycle
- grant_id  output  IW  index of requester that supplied current d_out

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active low: resetn=0 forces state immediately, independent of clk.
- Reset values:
  - d_out=0, d_out_vld=0, grant_id=0.
  - Priority pointer ptr=N_REQ-1, so requester 0 has highest priority first.
  - FSM=ARB.
- Output stage:
  - can_load = !d_out_vld | d_out_rdy, i.e. the stage is empty or is drained in the same cycle.
- Arbitration (combinational, state ARB):
  - Search req_vld starting at index ptr+1 modulo N_REQ, wrapping.
  - The first set bit is the winner w.
  - req_rdy = onehot(w) when can_load and any req_vld is set; otherwise 0.
  - req_rdy is never asserted for a requester with req_vld=0.
  - At most one req_rdy bit is set in any cycle.
- Transfer (rising edge with req_vld[w] & req_rdy[w]):
  - d_out <= req_data[w], grant_id <= w, d_out_vld <= 1, ptr <= w.
  - Latency: beat visible on d_out one cycle after acceptance.
- Drain:
  - If d_out_vld & d_out_rdy and no new transfer, then d_out_vld <= 0.
  - d_out and grant_id hold their last value.
- Simultaneous drain and load: the new beat replaces the old one with d_out_vld staying 1, giving full throughput of one beat per cycle.
- Backpressure:
  - While d_out_vld=1 and d_out_rdy=0, req_rdy=0.
  - d_out, grant_id and ptr are held stable.
- No requests:
  - req_rdy=0 and ptr is unchanged.
  - d_out_vld follows the drain rule.
- Fairness: with all requesters continuously valid and d_out_rdy=1, grants rotate 0,1,2,...,N_REQ-1,0,...
- Reset mid-operation: any pending d_out beat is discarded and ptr returns to N_REQ-1. Requesters must re-present their data.
- Data width: req_data slices are passed through unmodified; no arithmetic on data.

Optional Feature:
- Macro: SIMPLE_CONNECT_RR_ARB_BURST_HOLD_EN.
- Enabled:
  - Two-state FSM: ARB and LOCK, with a lock register lk (IW bits).
  - In ARB, when beat w is accepted with req_last[w]=0: go to LOCK, lk <= w.
  - In LOCK, only requester lk is eligible. req_rdy = onehot(lk) & can_load & req_vld[lk], and other requesters are never granted.
  - When a beat from lk is accepted with req_last[lk]=1: return to ARB, ptr <= lk.
  - A single-beat burst (req_last=1 on first beat) never enters LOCK.
  - Reset returns FSM to ARB.
- Disabled:
  - req_last is ignored and the FSM stays in ARB permanently.
  - Every beat is arbitrated independently.

Test Plan:
- Reset: resetn=0 asynchronously mid-cycle with d_out_vld=1 -> d_out_vld=0, d_out=0x00, grant_id=0 immediately, req_rdy=0.
- Rotation: req_vld=4'b1111, data i = 0xA0+i, d_out_rdy=1 for 8 cycles -> d_out sequence A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles, grant_id 0,1,2,3,0,1,2,3.
- Backpressure: one beat 0x5C from req 2, d_out_rdy=0 for 3 cycles -> d_out=0x5C and d_out_vld=1 held, req_rdy=0 throughout; d_out_rdy=1 -> drained, next winner req 3 if valid.
- Wrap and skip: ptr=2, req_vld=4'b0011 -> req 0 granted first, then req 1; req 2 and 3 are never granted.
- Drain and load in the same cycle: d_out_vld=1, d_out_rdy=1, req 1 valid with 0x33 -> next cycle d_out=0x33, d_out_vld remains 1, no bubble.
- Burst hold (macro enabled): req 1 sends 3 beats 0x10,0x11,0x12 with last on the third while req 0 and req 2 are valid -> output 10,11,12 uninterrupted, then req 2 granted. With the macro disabled, the same stimulus interleaves to 10, then req 2, then req 0 in round-robin order.
